arb_3to1_rr: RTL and testbench
==============================

# arb_3to1_rr

Round-robin arbiter that shares one 3-input datapath resource among three requesters. It drives the select of the downstream 3:1 select stage and returns a one-hot grant to each requester. It sits between the requesting units (e.g. ALU result, memory load data, immediate path) and the shared write-back mux or bus. Grants are registered and held until the owner releases; an optional hold limit forces release.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive granted cycles per owner, range 2..15. Used only when `ARB_TIMEOUT_EN` is defined.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `req` input 3: `req[i]` high means requester i wants the resource; level-sensitive.
- `gnt` output 3: one-hot grant, or all-zero when idle; registered.
- `gnt_valid` output 1: high when any `gnt` bit is high; registered.
- `sel` output 2: select for the 3:1 stage. Requester 0 is 2'b00, requester 1 is 2'b10, requester 2 is 2'b11; idle is 2'b00. Registered, always consistent with `gnt`.
- `timeout` output 1: one-cycle pulse when a grant is revoked by the hold limit. Constant 0 without `ARB_TIMEOUT_EN`.

## Operation
- State is two states: IDLE (no grant) and OWNED (one grant held).
- A last-owner pointer `last[1:0]` sets priority. Search order starts at `last+1` and wraps mod 3.
- IDLE:
  - If any `req` is high, grant the first requester in search order, go to OWNED, set `last` to that requester.
  - If no `req` is high, stay IDLE.
- OWNED, owner keeps `req` high:
  - Hold the grant.
  - Other requests are ignored, except for the hold limit.
- OWNED, owner drops `req`:
  - On the same edge, re-arbitrate among the other requesters that are high (zero-bubble handoff).
  - If none are high, go to IDLE with `gnt=0`.
- `req` bits of non-owners may toggle freely. Only their sampled value at an arbitration edge matters.
- Invariant: at most one `gnt` bit is high. `sel` and `gnt_valid` always match `gnt` in the same cycle.
- Reset values:
  - `gnt=3'b000`, `gnt_valid=0`, `sel=2'b00`, `timeout=0`.
  - State is IDLE, `last=2'd2`, so requester 0 has first priority.
  - Hold counter is 0.
- Reset asserted mid-grant: all outputs drop immediately (asynchronous), with no `timeout` pulse. After release, arbitration restarts from the reset priority.

## Timing
- Request-to-grant latency: `req[i]` sampled high at edge N while IDLE gives `gnt[i]` high after edge N. The grant is visible in cycle N+1.
- Release latency: owner `req` sampled low at edge N removes or moves the grant after edge N.
- Back-to-back handoff has no idle cycle between owners.
- A requester that drops and re-raises `req` while others wait gets a grant only after every waiting requester ahead of it in search order.
- Combinational paths: none from `req` to any output.
- Hold counter:
  - Clears on every new grant.
  - Increments each OWNED cycle and saturates at `MAX_HOLD`.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - When the owner has held for `MAX_HOLD` cycles and another requester is high at that edge, the grant moves to that requester.
  - `timeout` pulses high for exactly one cycle, aligned with the new grant.
  - `last` is updated, so the revoked requester becomes lowest priority.
  - If no other requester is high, the owner keeps the grant, the counter restarts at 0, and there is no pulse.
- `ARB_TIMEOUT_EN` not defined:
  - No hold counter and no timeout logic.
  - `timeout` is tied to 0.
  - The grant is held indefinitely while the owner's `req` stays high.

## Test plan
- Reset, then `req=3'b111` held: `gnt=3'b001`, `sel=2'b00` one cycle later. Drop `req[0]`: next cycle `gnt=3'b010`, `sel=2'b10`. Drop `req[1]`: next cycle `gnt=3'b100`, `sel=2'b11`. Drop `req[2]`: next cycle `gnt=0`, `gnt_valid=0`.
- Rotation fairness:
  - Requester 2 was last owner, then `req=3'b011` is raised: grant goes to 0.
  - 0 releases: grant goes to 1.
  - 1 releases while `req[0]` is re-raised: grant goes to 0 with no idle cycle.
- Single requester: `req=3'b010` pulsed for 1 cycle gives `gnt=3'b010` for exactly 1 cycle, then idle.
- Hold limit (`ARB_TIMEOUT_EN`, `MAX_HOLD=4`):
  - `req=3'b011` held: `gnt[0]` for 4 cycles, then `gnt=3'b010` with a `timeout` pulse of 1 cycle.
  - `req=3'b001` alone holds beyond 4 cycles with `timeout=0`.
- Without `ARB_TIMEOUT_EN`: `req=3'b011` held for 50 cycles keeps `gnt=3'b001` throughout, and `timeout` is never high.
- Asynchronous reset: assert `reset_n=0` mid-cycle while `gnt=3'b100`. `gnt`, `sel`, `gnt_valid` and `timeout` go to 0 before the next edge. After release with `req=3'b111`, the first grant is to requester 0.

Source files
------------

// File: rtl/arb_3to1_rr.sv
// Round-robin arbiter for three requesters sharing one 3:1 select stage.
// Define ARB_TIMEOUT_EN to enable the MAX_HOLD forced-release limit.
module arb_3to1_rr #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] req,
    output logic [2:0] gnt,
    output logic       gnt_valid,
    output logic [1:0] sel,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] last_reg, last_next;
    logic [2:0] gnt_reg, gnt_next;
    logic [1:0] sel_reg, sel_next;
    logic       gnt_valid_reg;
    logic [3:0] cand;
    logic [1:0] order [3];
    logic       pick_found;
    logic [1:0] pick_idx;
    logic       owner_req;
    logic       take;
    logic       expire;

    // The owner is masked out, so a forced release can never re-pick it.
    assign cand      = {1'b0, req & ~gnt_reg};
    assign owner_req = |(req & gnt_reg);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_order
            logic [2:0] pos;
            assign pos       = {1'b0, last_reg} + 3'(gi + 1);
            assign order[gi] = (pos >= 3'd3) ? 2'(pos - 3'd3) : pos[1:0];
        end
    endgenerate

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (cand[order[k]]) begin
                pick_found = 1'b1;
                pick_idx   = order[k];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [3:0] hold_reg, hold_next;
    logic       timeout_reg, timeout_next;

    // hold_reg counts completed owned cycles, so MAX_HOLD-1 marks the last one.
    assign expire = (hold_reg == 4'(MAX_HOLD - 1));
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        gnt_next   = gnt_reg;
        take       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_found) take = 1'b1;
            end
            OWNED: begin
                if (!owner_req) begin
                    if (pick_found) begin
                        take = 1'b1;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = 3'b000;
                    end
                end else if (expire && pick_found) begin
                    take = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (take) begin
            state_next = OWNED;
            last_next  = pick_idx;
            gnt_next   = 3'(3'b001 << pick_idx);
        end
    end

    always_comb begin
        sel_next = 2'b00;
        case (gnt_next)
            3'b010:  sel_next = 2'b10;
            3'b100:  sel_next = 2'b11;
            default: sel_next = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            last_reg      <= 2'd2;
            gnt_reg       <= 3'b000;
            sel_reg       <= 2'b00;
            gnt_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            last_reg      <= last_next;
            gnt_reg       <= gnt_next;
            sel_reg       <= sel_next;
            gnt_valid_reg <= |gnt_next;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_comb begin
        hold_next    = hold_reg;
        timeout_next = (state_reg == OWNED) && owner_req && expire && pick_found;
        if (take) begin
            hold_next = 4'd0;
        end else if (state_next == OWNED) begin
            if (expire) begin
                hold_next = 4'd0;
            end else if (hold_reg < 4'(MAX_HOLD)) begin
                hold_next = hold_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_reg    <= 4'd0;
            timeout_reg <= 1'b0;
        end else begin
            hold_reg    <= hold_next;
            timeout_reg <= timeout_next;
        end
    end

    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_reg;
    assign gnt_valid = gnt_valid_reg;
    assign sel       = sel_reg;

endmodule

// File: tb/tb_arb_3to1_rr.sv
// Scoreboard bench for arb_3to1_rr: the driver queues the expected grant for
// each cycle, a monitor pops and compares one entry per clock edge.
module tb_arb_3to1_rr;

    logic       clk;
    logic       reset_n;
    logic [2:0] req;
    logic [2:0] gnt;
    logic       gnt_valid;
    logic [1:0] sel;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] req;
        logic [2:0] gnt;
        logic       to;
        string      name;
    } exp_t;

    exp_t exp_q[$];

    arb_3to1_rr #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .sel       (sel),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] sel_of(input logic [2:0] g);
        case (g)
            3'b010:  return 2'b10;
            3'b100:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    task automatic check(input string name, input string field, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s %s: actual=%0h required=%0h", name, field, act, want);
        end
    endtask

    task automatic check_all(input string name, input logic [2:0] g, input logic to);
        check(name, "gnt", int'(gnt), int'(g));
        check(name, "gnt_valid", int'(gnt_valid), int'(|g));
        check(name, "sel", int'(sel), int'(sel_of(g)));
        check(name, "timeout", int'(timeout), int'(to));
    endtask

    // Drive req for the next edge and queue what the outputs must be after it.
    task automatic step(input logic [2:0] r, input logic [2:0] g, input logic to, input string name);
        exp_t e;
        @(negedge clk);
        req    = r;
        e.req  = r;
        e.gnt  = g;
        e.to   = to;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        @(posedge clk);
        #2;
        check("drain", "queue_empty", exp_q.size(), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("txn %-10s req=%b gnt=%b sel=%b vld=%b to=%b (want gnt=%b to=%b)",
                         e.name, e.req, gnt, sel, gnt_valid, timeout, e.gnt, e.to);
                check_all(e.name, e.gnt, e.to);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        reset_n = 1'b1;
        req     = 3'b000;
        #1 reset_n = 1'b0;
        #1;
        check_all("reset", 3'b000, 1'b0);
        #21 reset_n = 1'b1;

        // Sequential release walks the grant 0 -> 1 -> 2 -> idle.
        step(3'b111, 3'b001, 1'b0, "all_req");
        step(3'b111, 3'b001, 1'b0, "all_hold");
        step(3'b110, 3'b010, 1'b0, "drop0");
        step(3'b110, 3'b010, 1'b0, "hold1");
        step(3'b100, 3'b100, 1'b0, "drop1");
        step(3'b100, 3'b100, 1'b0, "hold2");
        step(3'b000, 3'b000, 1'b0, "drop2");
        step(3'b000, 3'b000, 1'b0, "idle");

        // Rotation after requester 2 owned last, with zero-bubble handoff.
        step(3'b011, 3'b001, 1'b0, "rot_0");
        step(3'b011, 3'b001, 1'b0, "rot_0h");
        step(3'b010, 3'b010, 1'b0, "rot_1");
        step(3'b001, 3'b001, 1'b0, "rot_back0");
        step(3'b000, 3'b000, 1'b0, "rot_idle");

        // One-cycle pulse from a lone requester.
        step(3'b010, 3'b010, 1'b0, "pulse1");
        step(3'b000, 3'b000, 1'b0, "pulse_off");
        step(3'b000, 3'b000, 1'b0, "pulse_idl");

        // A re-raised requester waits behind those ahead in search order.
        step(3'b111, 3'b100, 1'b0, "fair_2");
        step(3'b011, 3'b001, 1'b0, "fair_0");
        step(3'b110, 3'b010, 1'b0, "fair_1");
        step(3'b000, 3'b000, 1'b0, "fair_idle");

`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) step(3'b011, 3'b001, 1'b0, "hold_0");
        step(3'b011, 3'b010, 1'b1, "tmo_to1");
        step(3'b011, 3'b010, 1'b0, "after_tmo");
        step(3'b001, 3'b001, 1'b0, "solo_0");
        for (int i = 0; i < 6; i++) step(3'b001, 3'b001, 1'b0, "solo_hold");
        step(3'b000, 3'b000, 1'b0, "solo_idle");
`else
        for (int i = 0; i < 50; i++) step(3'b011, 3'b001, 1'b0, "no_limit");
        step(3'b000, 3'b000, 1'b0, "nl_idle");
`endif

        // Asynchronous reset while requester 2 holds the grant.
        step(3'b100, 3'b100, 1'b0, "pre_rst2");
        step(3'b100, 3'b100, 1'b0, "pre_rst2h");
        drain();
        reset_n = 1'b0;
        req     = 3'b111;
        #1;
        check_all("async_rst", 3'b000, 1'b0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        $display("txn %-10s req=%b gnt=%b sel=%b vld=%b to=%b (want gnt=001 to=0)",
                 "post_rst", req, gnt, sel, gnt_valid, timeout);
        check_all("post_rst", 3'b001, 1'b0);
        step(3'b000, 3'b000, 1'b0, "final_idle");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
